fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the synchronous FIFO. It drains the FIFO by driving its read enable and absorbs the FIFO's 1-cycle registered read latency. Data is presented downstream on a valid/ready stream through a small skid buffer. It sits between the FIFO's o_data/o_empty/i_rd_en pins and any consumer that may back-pressure.

Parameters:
BUF_DEPTH, 2, output skid-buffer entries; legal values are 2 or more; 2 is the minimum for 1 word/cycle.
Data width comes from the `DATA_WIDTH macro in fifo.vh; it is not a parameter.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_en  input  1  drain enable
i_fifo_empty  input  1  FIFO empty flag
i_fifo_data  input  `DATA_WIDTH  FIFO read data, valid the cycle after a read
o_fifo_rd_en  output  1  FIFO read enable (combinational)
o_data  output  `DATA_WIDTH  stream data (head of the skid buffer)
o_valid  output  1  stream valid
i_ready  input  1  stream ready from the consumer
o_idle  output  1  high in IDLE state

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high; it is sampled only on the rising edge of i_clk.
- Reset values:
  - occupancy = 0, inflight = 0, head/tail pointers = 0
  - o_valid = 0, o_data = 0, o_idle = 1, state = IDLE
  - Asserting reset mid-operation discards buffered and in-flight words. The FIFO's own contents are untouched.
- pop = o_valid & i_ready. A word transfers downstream on every cycle where pop is 1.
- Read issue: o_fifo_rd_en = (state==ACTIVE) & !i_fifo_empty & ((occupancy + inflight - pop) < BUF_DEPTH).
  - Never asserted while i_fifo_empty = 1.
  - o_fifo_rd_en depends combinationally on i_ready.
- inflight is a 1-bit register, equal to last cycle's o_fifo_rd_en. When inflight = 1, i_fifo_data is written at tail at the clock edge and tail increments.
- Latency: rd_en in cycle N, FIFO data in cycle N+1, o_valid = 1 in cycle N+2.
- Throughput: sustained 1 word/cycle with i_ready held high.
- Buffer: circular, BUF_DEPTH entries.
  - Pointers wrap BUF_DEPTH-1 -> 0.
  - occupancy width is clog2(BUF_DEPTH+1).
  - Simultaneous push and pop leaves occupancy unchanged.
  - o_data = buf[head] and o_valid = (occupancy != 0), both registered-state derived.
  - The buffer cannot overflow, because capacity is reserved at issue time.
- Stream rules:
  - Once o_valid = 1, o_data is held stable until pop.
  - o_valid never drops without a pop, except on reset.
- FSM:
  - IDLE -> ACTIVE when i_en = 1.
  - ACTIVE -> STOPPING when i_en = 0. No new reads are issued from this point.
  - STOPPING -> IDLE when inflight = 0, occupancy = 0 and i_en = 0.
  - STOPPING -> ACTIVE when i_en = 1. This takes priority.
  - In STOPPING, the in-flight word still lands and buffered words still drain.
- o_idle = (state == IDLE).
- An empty FIFO in ACTIVE stalls harmlessly: no read is issued and the controller stays in ACTIVE.

Optional Feature:
Macro: FIFO_RD_CNT_EN.
- Defined:
  - Adds output o_rd_count [31:0], which increments by 1 per pop and wraps 0xFFFFFFFF -> 0.
  - Reset value is 0.
  - The count is held (not cleared) across IDLE.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
1. Basic drain: preload the FIFO with 0x11, 0x22, 0x33; assert i_en with i_ready = 1.
   -> rd_en high for 3 consecutive cycles.
   -> o_valid high for 3 consecutive cycles starting 2 cycles after the first rd_en.
   -> Data out 0x11, 0x22, 0x33 in order.
2. Back-pressure: FIFO holds 8 words; i_ready = 0 for 10 cycles, then 1.
   -> Exactly BUF_DEPTH = 2 reads issued, then rd_en held low.
   -> o_data holds the first word stable.
   -> After release, all 8 words arrive in order, 1 per cycle, no loss or duplication.
3. Random i_ready (50%) over 1000 words.
   -> Output sequence matches the scoreboard.
   -> rd_en is never high while i_fifo_empty = 1.
   -> occupancy never exceeds 2.
4. Stop mid-stream: drop i_en while inflight = 1 and occupancy = 1.
   -> Both words are delivered, no further reads are issued, and o_idle rises after the last pop.
   -> Re-asserting i_en while in STOPPING returns to ACTIVE with no idle cycle.
5. Reset mid-operation: pulse i_rst for 1 cycle while occupancy = 2.
   -> Next cycle: o_valid = 0, o_idle = 1, o_fifo_rd_en = 0.
   -> The remaining FIFO words drain correctly after i_en is reasserted.
6. With FIFO_RD_CNT_EN defined: 5 pops.
   -> o_rd_count = 5, and it resets to 0 on i_rst.
   -> Preloading the counter to 0xFFFFFFFF (force) and issuing 1 pop gives 0.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// Downstream valid/ready stream of the FIFO read controller.
// `DATA_WIDTH normally comes from fifo.vh; 8 is used when it is absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface fifo_rd_ctrl_if;
    logic [`DATA_WIDTH-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues reads and absorbs the 1-cycle latency into a skid buffer.
// Optional read counter o_rd_count enabled by defining FIFO_RD_CNT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module fifo_rd_ctrl #(
    parameter int BUF_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_fifo_empty,
    input  logic [`DATA_WIDTH-1:0] i_fifo_data,
    output logic                   o_fifo_rd_en,
    output logic                   o_idle,
`ifdef FIFO_RD_CNT_EN
    output logic [31:0]            o_rd_count,
`endif
    fifo_rd_ctrl_if.master         bus
);

    localparam int DW = `DATA_WIDTH;
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [OW:0]   DEPTH_L = (OW + 1)'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_L  = PW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        STOPPING
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OW-1:0]   r_occ;
    logic            r_inflight;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [DW-1:0]   r_buf [BUF_DEPTH];

    logic            w_pop;
    logic            w_push;
    logic [OW:0]     w_fill;
    logic            w_room;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_L) ? '0 : p + PW'(1);
    endfunction

    assign w_pop  = bus.o_valid & bus.i_ready;
    assign w_push = r_inflight;

    // Reserve room for the word in flight so the buffer can never overflow.
    assign w_fill = {1'b0, r_occ}
                  + {{OW{1'b0}}, r_inflight}
                  - {{OW{1'b0}}, w_pop};
    assign w_room = (w_fill < DEPTH_L);

    assign o_fifo_rd_en = (r_state == ACTIVE) & ~i_fifo_empty & w_room;
    assign o_idle       = (r_state == IDLE);
    assign bus.o_valid  = (r_occ != '0);
    assign bus.o_data   = r_buf[r_head];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_en) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!i_en) begin
                    w_state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (i_en) begin
                    w_state_nxt = ACTIVE;
                end else if (!r_inflight && (r_occ == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_fifo_rd_en;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
        end
    end

    // Cleared on reset so o_data reads zero until the first word lands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_push) begin
            r_buf[r_tail] <= i_fifo_data;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [31:0] r_rd_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 32'd1;
        end
    end

    assign o_rd_count = r_rd_count;
`endif

endmodule
